// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: 50% duty outputs plus a rising-edge tick per channel.
// Half-period writes land in a shadow register and reach the counter only at a toggle, sync or idle.
module clk_div_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 17,
    parameter int DEFAULT_HALF = 49999,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  act_q [NUM_CH];
    logic [CNT_W-1:0]  act_d [NUM_CH];
    logic [CNT_W-1:0]  shd_q [NUM_CH];
    logic [CNT_W-1:0]  shd_d [NUM_CH];
    logic [NUM_CH-1:0] out_q;
    logic [NUM_CH-1:0] out_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] wr_hit;

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            // Out-of-range channel numbers never match, so such writes are dropped.
            wr_hit[ch] = wr_en && (wr_ch == CH_W'(ch));
            // shd_d doubles as the load value, giving a same-cycle write priority over the old shadow.
            shd_d[ch]  = wr_hit[ch] ? wr_half : shd_q[ch];
            cnt_d[ch]  = cnt_q[ch];
            act_d[ch]  = act_q[ch];
            out_d[ch]  = out_q[ch];
            tick_d[ch] = 1'b0;
            if (sync || !en[ch]) begin
                cnt_d[ch] = '0;
                out_d[ch] = 1'b0;
                act_d[ch] = shd_d[ch];
            end else if (cnt_q[ch] == act_q[ch]) begin
                cnt_d[ch]  = '0;
                out_d[ch]  = ~out_q[ch];
                tick_d[ch] = ~out_q[ch];
                act_d[ch]  = shd_d[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= '0;
                act_q[ch] <= DEF_HALF;
                shd_q[ch] <= DEF_HALF;
            end
            out_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
                act_q[ch] <= act_d[ch];
                shd_q[ch] <= shd_d[ch];
            end
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: a 4-channel default instance and a 3-channel instance share all stimulus,
// checked every cycle against a countdown model plus hand-computed edge counts.
module tb_clk_div_multi;

    logic        clk;
    logic        rst_n;
    logic [3:0]  en;
    logic        sync;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [16:0] wr_half;
    logic [3:0]  clk_out_a;
    logic [3:0]  tick_a;
    logic [2:0]  clk_out_b;
    logic [2:0]  tick_b;
    logic [6:0]  co_all;

    int n_assert = 0;
    int n_fail   = 0;

    // model state: channels 0..3 -> instance A, 4..6 -> instance B
    int m_rem [7];
    int m_s   [7];
    bit m_out [7];
    bit m_tick[7];

    clk_div_multi u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_half(wr_half), .clk_out(clk_out_a), .tick(tick_a)
    );

    clk_div_multi #(.NUM_CH(3), .CNT_W(17), .DEFAULT_HALF(20)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en[2:0]), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_half(wr_half), .clk_out(clk_out_b), .tick(tick_b)
    );

    assign co_all = {clk_out_b, clk_out_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int def_half(input int c);
        return (c < 4) ? 49999 : 20;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each channel counts down the edges left until its next toggle.
    initial begin
        for (int c = 0; c < 7; c++) begin
            m_s[c] = def_half(c); m_rem[c] = def_half(c) + 1; m_out[c] = 0; m_tick[c] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int c = 0; c < 7; c++) begin
                int k;
                int sn;
                bit hit;
                bit e;
                if (!rst_n) begin
                    m_s[c] = def_half(c); m_rem[c] = def_half(c) + 1; m_out[c] = 0; m_tick[c] = 0;
                end else begin
                    k   = (c < 4) ? c : c - 4;
                    hit = wr_en && (int'(wr_ch) == k);
                    e   = en[k];
                    sn  = hit ? int'(wr_half) : m_s[c];
                    if (sync || !e) begin
                        m_out[c] = 0; m_tick[c] = 0; m_rem[c] = sn + 1;
                    end else begin
                        m_rem[c]--;
                        if (m_rem[c] == 0) begin
                            m_out[c]  = !m_out[c];
                            m_tick[c] = m_out[c];
                            m_rem[c]  = sn + 1;
                        end else begin
                            m_tick[c] = 0;
                        end
                    end
                    m_s[c] = sn;
                end
            end
        end
    end

    initial begin
        logic [3:0] eo_a, et_a;
        logic [2:0] eo_b, et_b;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin eo_a[c] = m_out[c]; et_a[c] = m_tick[c]; end
            for (int c = 0; c < 3; c++) begin eo_b[c] = m_out[c+4]; et_b[c] = m_tick[c+4]; end
            check("model_clk_out_a", clk_out_a, eo_a);
            check("model_tick_a", tick_a, et_a);
            check("model_clk_out_b", clk_out_b, eo_b);
            check("model_tick_b", tick_b, et_b);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_change(input int idx, output int n);
        logic v0;
        v0 = co_all[idx];
        n  = 0;
        while (n < 60000) begin
            step(1);
            n++;
            if (co_all[idx] != v0) break;
        end
        if (co_all[idx] == v0) begin
            n_assert++;
            n_fail++;
            $display("FAIL wait_change bit %0d: no toggle within %0d edges", idx, n);
        end
    endtask

    task automatic write_half(input int ch, input int h);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_half = 17'(h);
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic first_rises(output int first[7]);
        for (int b = 0; b < 7; b++) first[b] = -1;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            for (int b = 0; b < 7; b++)
                if (first[b] < 0 && co_all[b]) first[b] = e;
        end
    endtask

    initial begin
        int n;
        int n2;
        int fr[7];
        rst_n = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_half = '0;
        step(5);
        check("rst_clk_out_a", clk_out_a, 0);
        check("rst_tick_a", tick_a, 0);
        check("rst_clk_out_b", clk_out_b, 0);

        // default divisor on channel 0
        rst_n = 1'b1; en = 4'b0001;
        wait_change(0, n);
        check("ch0_default_first_rise", n, 50000);
        check("ch0_default_tick", tick_a[0], 1);
        check("ch1_3_idle", clk_out_a[3:1], 0);

        // H=3 written while idle
        en = 4'b0000;
        write_half(2, 3);
        en = 4'b0100;
        wait_change(2, n);
        check("ch2_h3_first_rise", n, 4);
        check("ch2_h3_tick_high", tick_a[2], 1);
        step(1);
        check("ch2_h3_tick_low", tick_a[2], 0);
        wait_change(2, n);
        wait_change(2, n2);
        check("ch2_h3_period", n + n2 + 1, 8);

        // H=0, then bypass write coinciding with a toggle
        write_half(1, 0);
        en = 4'b0110;
        wait_change(1, n);
        check("ch1_h0_first_rise", n, 1);
        wait_change(1, n);
        wait_change(1, n2);
        check("ch1_h0_period", n + n2, 2);
        write_half(1, 5);
        wait_change(1, n);
        check("ch1_bypass_half", n, 6);

        // boundary-aligned update on channel 0
        en = 4'b0000;
        write_half(0, 9);
        en = 4'b0001;
        wait_change(0, n);
        check("ch0_h9_first_rise", n, 10);
        step(4);
        write_half(0, 2);
        wait_change(0, n);
        check("ch0_old_half_completes", n + 5, 10);
        wait_change(0, n);
        check("ch0_new_half_a", n, 3);
        wait_change(0, n);
        check("ch0_new_half_b", n, 3);
        write_half(0, 9);
        wait_change(0, n);
        check("ch0_h2_before_reload", n + 1, 3);
        step(8);
        write_half(0, 1);
        wait_change(0, n);
        check("ch0_late_write_half", n + 9, 10);
        wait_change(0, n);
        check("ch0_h1_half", n, 2);

        // enable drop while high
        if (!clk_out_a[0]) wait_change(0, n);
        step(1);
        en = en & 4'b1110;
        step(1);
        check("ch0_en_drop", clk_out_a[0], 0);

        // sync with mixed divisors
        en = 4'b0000;
        for (int i = 0; i < 4; i++) write_half(i, 3 + 2 * i);
        en = 4'b1111;
        step(7);
        sync = 1'b1;
        step(1);
        check("sync_clk_out_a", clk_out_a, 0);
        check("sync_clk_out_b", clk_out_b, 0);
        check("sync_tick_a", tick_a, 0);
        sync = 1'b0;
        first_rises(fr);
        check("sync_rise_a0", fr[0], 4);
        check("sync_rise_a1", fr[1], 6);
        check("sync_rise_a2", fr[2], 8);
        check("sync_rise_a3", fr[3], 10);
        check("sync_rise_b0", fr[4], 4);
        check("sync_rise_b2", fr[6], 8);

        // wr_ch=3 is valid for A, out of range for B
        write_half(3, 1);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        first_rises(fr);
        check("inv_rise_a3", fr[3], 2);
        check("inv_rise_b0", fr[4], 4);
        check("inv_rise_b1", fr[5], 6);
        check("inv_rise_b2", fr[6], 8);

        // randomized traffic
        en = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) en = 4'($urandom_range(0, 15));
            sync    = ($urandom_range(0, 96) == 0);
            wr_en   = ($urandom_range(0, 15) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_half = 17'($urandom_range(0, 12));
            step(1);
        end
        sync = 1'b0; wr_en = 1'b0;

        // asynchronous reset between edges
        en = 4'b1111;
        for (int i = 0; i < 4; i++) write_half(i, 0);
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clk_out_a", clk_out_a, 0);
        check("async_rst_tick_a", tick_a, 0);
        check("async_rst_clk_out_b", clk_out_b, 0);
        step(2);
        rst_n = 1'b1; en = 4'b0001;
        wait_change(4, n);
        check("b0_default_after_reset", n, 21);
        check("a0_default_not_yet", clk_out_a[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
